// File: rtl/full_adder_pkg.sv
// Shared constants and the per-bit full-adder equations for the full_adder cell.
package full_adder_pkg;

  localparam int   FA_MAX_WIDTH = 64;
  localparam int   FA_RST_SUM   = 0;
  localparam logic FA_RST_CARRY = 1'b0;

  function automatic logic fa_sum(input logic a, input logic b, input logic k);
    return a ^ b ^ k;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic k);
    return (a & b) | (k & (a ^ b));
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One combinational full-adder slice; the top chains these into a ripple-carry adder.
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = fa_sum(a, b, cin);
  assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {c,s} <= a + b + cin, one cycle latency, sync active-high reset.
// Optional simulation-only input/result checks are enabled by defining FULL_ADDER_CHECK_EN.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_chk
    $error("full_adder: WIDTH must be in 1..64");
  end

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;
  logic             c_d;
  logic             c_q;

  assign k[0] = cin;

  // Carry ripples from slice i to slice i+1; this chain is the critical path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    full_adder_bit u_bit (
      .a   (a[i]),
      .b   (b[i]),
      .cin (k[i]),
      .s   (s_d[i]),
      .cout(k[i+1])
    );
  end

  assign c_d = k[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= WIDTH'(FA_RST_SUM);
      c_q <= FA_RST_CARRY;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s = s_q;
  assign c = c_q;

`ifdef FULL_ADDER_CHECK_EN
  logic [WIDTH:0] chk_exp_q;
  logic           chk_vld_q;

  // Result check compares the flops against the value captured at the previous edge.
  always @(posedge clk) begin
    if (!rst && $isunknown({a, b, cin}))
      $error("full_adder: X/Z on inputs a=%h b=%h cin=%b", a, b, cin);
    if (chk_vld_q === 1'b1 && {c_q, s_q} !== chk_exp_q)
      $error("full_adder: result %h, behavioural %h", {c_q, s_q}, chk_exp_q);
    chk_exp_q <= (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
    chk_vld_q <= !rst && !$isunknown({a, b, cin});
  end
`else
  // Default build: no checking logic.
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 4 and 64 against an arithmetic reference.
module tb_full_adder;

  logic        clk;
  logic        rst;
  logic        a1, b1, cin1;
  logic        s1, c1;
  logic [3:0]  a4, b4, s4;
  logic        cin4, c4;
  logic [63:0] a64, b64, s64;
  logic        cin64, c64;

  int checks = 0;
  int errors = 0;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .s(s1), .c(c1)
  );
  full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .s(s4), .c(c4)
  );
  full_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .a(a64), .b(b64), .cin(cin64), .s(s64), .c(c64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {c,s} is the low w+1 bits of the integer sum a + b + cin.
  function automatic logic [64:0] ref_sum(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin);
    logic [64:0] full;
    full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    for (int i = w + 1; i < 65; i++) full[i] = 1'b0;
    return full;
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r,
                       input logic a_1, input logic b_1, input logic c_1,
                       input logic [3:0] a_4, input logic [3:0] b_4, input logic c_4,
                       input logic [63:0] a_64, input logic [63:0] b_64, input logic c_64);
    @(negedge clk);
    rst = r;
    a1 = a_1;   b1 = b_1;   cin1 = c_1;
    a4 = a_4;   b4 = b_4;   cin4 = c_4;
    a64 = a_64; b64 = b_64; cin64 = c_64;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of all three instances for the inputs currently applied.
  task automatic check_all(input string tag);
    logic [64:0] e1, e4, e64;
    e1  = rst ? 65'd0 : ref_sum(1,  {63'd0, a1}, {63'd0, b1}, cin1);
    e4  = rst ? 65'd0 : ref_sum(4,  {60'd0, a4}, {60'd0, b4}, cin4);
    e64 = rst ? 65'd0 : ref_sum(64, a64, b64, cin64);
    check({tag, "_w1"},  {63'd0, c1, s1},  e1);
    check({tag, "_w4"},  {60'd0, c4, s4},  e4);
    check({tag, "_w64"}, {c64, s64},       e64);
  endtask

  initial begin
    logic [2:0]  v;
    logic [63:0] ra, rb;
    logic [1:0]  exp_cs [8];
    exp_cs = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a4 = 4'd1; b4 = 4'd1; cin4 = 1'b1;
    a64 = 64'd1; b64 = 64'd1; cin64 = 1'b1;

    // Reset held two cycles with all inputs at 1
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1, 1'b1, 64'd1, 64'd1, 1'b1);
      check("rst_s1", {64'd0, s1}, 65'd0);
      check("rst_c1", {64'd0, c1}, 65'd0);
      check("rst_w4", {60'd0, c4, s4}, 65'd0);
      check("rst_w64", {c64, s64}, 65'd0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1, 1'b1, 64'd1, 64'd1, 1'b1);
    check("release_w1", {63'd0, c1, s1}, 65'b11);
    check("release_w4", {60'd0, c4, s4}, 65'd3);
    check_all("release");

    // Exhaustive 1-bit truth table
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(1'b0, v[2], v[1], v[0], 4'(i), 4'(7 - i), v[0],
            64'(i) << 60, 64'hFFFF_FFFF_FFFF_FFFF, v[1]);
      check("exh_w1", {63'd0, c1, s1}, {63'd0, exp_cs[i]});
      check_all("exh");
    end

    // Hold 011 for three cycles; also sample mid-cycle for glitches
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd6, 1'b1, 64'd5, 64'd6, 1'b0);
      check("hold_w1", {63'd0, c1, s1}, 65'b10);
      #3;
      check("hold_mid_w1", {63'd0, c1, s1}, 65'b10);
    end

    // 4-bit wrap-around
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    check("wrap_a_w4", {60'd0, c4, s4}, {60'd0, 1'b1, 4'd0});
    check("wrap_a_w64", {c64, s64}, {1'b1, 64'd0});
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("wrap_b_w4", {60'd0, c4, s4}, {60'd0, 1'b1, 4'd15});
    check("wrap_b_w64", {c64, s64}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

    // Reset mid-stream discards the in-flight 7+8
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd8, 1'b0, 64'd7, 64'd8, 1'b0);
    check("midrst_w4", {60'd0, c4, s4}, 65'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd3, 1'b0, 64'd2, 64'd3, 1'b0);
    check("after_rst_w4", {60'd0, c4, s4}, 65'd5);
    check_all("after_rst");

    // Random operands with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i % 50 == 7) begin
        ra = 64'hFFFF_FFFF_FFFF_FFFF;
        rb = 64'd0;
      end
      drive(($urandom_range(0, 19) == 0), 1'($urandom()), 1'($urandom()), 1'($urandom()),
            ra[3:0], rb[3:0], 1'($urandom()), ra, rb, ((i % 50 == 7) ? 1'b1 : 1'($urandom())));
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Registered full adder. It adds two operands and a carry-in, producing a sum and a carry-out. It is a leaf arithmetic cell: the default 1-bit configuration is a single full-adder slice, and wider instances cascade slices into a ripple-carry chain. Outputs are captured in flops on the single system clock, so downstream logic sees stable, glitch-free results.

## Interface
Parameters:
- WIDTH, default 1, operand and sum width in bits; legal values are 1 to 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- cin  input  1  carry-in, weight 2^0.
- s  output  WIDTH  registered sum, equal to (a + b + cin) mod 2^WIDTH.
- c  output  1  registered carry-out, equal to bit WIDTH of (a + b + cin).

## Operation
- Combinational core: the full sum is computed as WIDTH+1 bits, {c_next, s_next} = a + b + cin.
  - Per bit i: s_i = a_i ^ b_i ^ k_i and k_{i+1} = (a_i & b_i) | (k_i & (a_i ^ b_i)), where k_0 = cin.
  - c_next = k_WIDTH.
- Register stage: s and c load s_next and c_next on every rising clk edge while rst = 0.
- There is no enable and no handshake. Inputs are sampled every cycle.
- Overflow wraps silently modulo 2^WIDTH; the carry is reported only on c.
- The output register holds no other state.

## Timing
- Latency is 1 cycle. Inputs present before rising edge N appear on s and c after edge N and stay stable until edge N+1.
- Throughput is one new operand set per cycle.
- Reset:
  - If rst = 1 at a rising edge, s becomes 0 and c becomes 0 after that edge. Reset has priority over the inputs.
  - Reset asserted mid-stream discards the in-flight result.
  - The first edge with rst = 0 loads the current inputs normally.
- Before the first reset edge, output values are undefined. Benches apply reset for at least 1 cycle.
- Timing closure: the critical path is the ripple chain, WIDTH carry stages, from the input pins to the s/c flops.

## Configuration
- FULL_ADDER_CHECK_EN defined: the block includes simulation-only checks.
  - At each edge with rst = 0, report an error if a, b, or cin contains X or Z.
  - One cycle later, report an error if {c,s} differs from the registered value of a + b + cin computed behaviourally.
  - The checks add no synthesizable logic.
- FULL_ADDER_CHECK_EN undefined: no checks are present. Synthesized logic is identical in both cases.

## Structure
- Package full_adder_pkg:
  - FA_MAX_WIDTH = 64.
  - FA_RST_SUM = 0.
  - FA_RST_CARRY = 0.
- Sub-module full_adder_bit:
  - Purely combinational 1-bit slice with ports a, b, cin, s, cout.
  - Instantiated WIDTH times by a generate loop, with the carry chained from slice i to slice i+1.
- The top level holds the WIDTH+1 output flops, the reset mux, and the optional check block.

## Test plan
- Reset: hold rst = 1 for 2 cycles with a = b = cin = 1 → s = 0 and c = 0 during reset; the first edge after release gives s = 1 and c = 1.
- Exhaustive, WIDTH = 1: apply {a,b,cin} = 000 through 111, one value per cycle → one cycle later {c,s} = 00, 01, 01, 10, 01, 10, 10, 11.
- Hold behaviour: keep {a,b,cin} = 011 for 3 cycles → {c,s} = 10 on each of those cycles, with no glitches between edges.
- Wrap-around, WIDTH = 4: a = 15, b = 0, cin = 1 → s = 0, c = 1. Then a = 15, b = 15, cin = 1 → s = 15, c = 1.
- Reset mid-stream, WIDTH = 4: apply a = 7, b = 8, cin = 0, assert rst at the next edge → s = 0, c = 0 (the result 15 is never shown). Release rst and apply a = 2, b = 3, cin = 0 → s = 5, c = 0.
- With FULL_ADDER_CHECK_EN defined: drive a = X for 1 cycle while rst = 0 → exactly one error report; all legal vectors produce no report.
